// File: rtl/stack_core_if.sv
// Instruction fetch and status bundle between stack_core and its environment.
interface stack_core_if #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 16,
   parameter int IADDR_W = 12
);
   localparam int DEPTH_W = $clog2(DEPTH + 1);

   logic [WIDTH+1:0]   i_instr;
   logic               i_instr_valid;
   logic [IADDR_W-1:0] o_iaddr;
   logic [WIDTH-1:0]   o_tos;
   logic [DEPTH_W-1:0] o_depth;
   logic               o_carry;
   logic               o_halted;
   logic               o_fault;
   logic               o_overflow;
   logic               o_underflow;

   // Core side: fetches instructions, drives pc and status.
   modport master (
      input  i_instr, i_instr_valid,
      output o_iaddr, o_tos, o_depth, o_carry,
      output o_halted, o_fault, o_overflow, o_underflow
   );

   // Program memory / environment side.
   modport slave (
      output i_instr, i_instr_valid,
      input  o_iaddr, o_tos, o_depth, o_carry,
      input  o_halted, o_fault, o_overflow, o_underflow
   );
endinterface

// File: rtl/stack_core.sv
// Single-issue stack machine: one instruction retires per clock while running.
// Top of stack lives in tos_q; entries below it sit in mem_q, with the entry
// directly under the top (S) at index depth-2.
module stack_core #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 16,
   parameter int IADDR_W = 12
) (
   input logic          i_clock,
   input logic          i_reset,
   stack_core_if.master bus
);
   localparam int DEPTH_W = $clog2(DEPTH + 1);
   localparam int IDX_W   = $clog2(DEPTH);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_HALT  = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   localparam logic [1:0] CLS_OP  = 2'b00;
   localparam logic [1:0] CLS_LIT = 2'b01;
   localparam logic [1:0] CLS_JMP = 2'b10;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_ADC  = 5'd2;
   localparam logic [4:0] OP_AND  = 5'd3;
   localparam logic [4:0] OP_OR   = 5'd4;
   localparam logic [4:0] OP_XOR  = 5'd5;
   localparam logic [4:0] OP_NOT  = 5'd6;
   localparam logic [4:0] OP_DUP  = 5'd7;
   localparam logic [4:0] OP_DROP = 5'd8;
   localparam logic [4:0] OP_SWAP = 5'd9;
   localparam logic [4:0] OP_OVER = 5'd10;

   localparam logic [2:0] CC_ALWAYS = 3'd0;
   localparam logic [2:0] CC_ZERO   = 3'd1;
   localparam logic [2:0] CC_NZERO  = 3'd2;
   localparam logic [2:0] CC_NEG    = 3'd3;
   localparam logic [2:0] CC_CARRY  = 3'd4;

   logic [1:0]         state_q, state_d;
   logic [IADDR_W-1:0] pc_q, pc_d;
   logic [WIDTH-1:0]   tos_q, tos_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx;

   logic [1:0]         cls;
   logic [WIDTH-1:0]   payload;
   logic [4:0]         op;
   logic [2:0]         cond;

   logic [IDX_W-1:0]   s_idx;
   logic [IDX_W-1:0]   push_idx;
   logic [WIDTH-1:0]   nos;
   logic               carry_in;
   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     diff_w;

   logic [1:0]         need;
   logic               grows;
   logic               taken;

   assign cls     = bus.i_instr[WIDTH+1:WIDTH];
   assign payload = bus.i_instr[WIDTH-1:0];
   assign op      = payload[4:0];
   assign cond    = payload[WIDTH-1:WIDTH-3];

   // S sits just below the top; a push spills the old top into the next slot.
   assign s_idx    = IDX_W'(depth_q - DEPTH_W'(2));
   assign push_idx = IDX_W'(depth_q - DEPTH_W'(1));
   assign nos      = mem_q[s_idx];

   // Carry/borrow come out of one extra bit on the unsigned sum and difference.
   assign carry_in = (op == OP_ADC) & carry_q;
   assign sum_w    = {1'b0, nos} + {1'b0, tos_q} + {{WIDTH{1'b0}}, carry_in};
   assign diff_w   = {1'b0, nos} - {1'b0, tos_q};

   // Decode how many operands the instruction consumes and whether it pushes.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      need  = 2'd0;
      grows = 1'b0;
      case (cls)
         CLS_LIT: grows = 1'b1;
         CLS_OP: begin
            if (op <= OP_XOR) begin
               need = 2'd2;
            end else begin
               case (op)
                  OP_NOT, OP_DROP: need = 2'd1;
                  OP_DUP: begin
                     need  = 2'd1;
                     grows = 1'b1;
                  end
                  OP_SWAP: need = 2'd2;
                  OP_OVER: begin
                     need  = 2'd2;
                     grows = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         CLS_JMP: if (cond == CC_ZERO || cond == CC_NZERO || cond == CC_NEG) need = 2'd1;
         default: ;
      endcase
   end

   // Evaluate the jump condition against the current top and carry.
   always_comb begin
      case (cond)
         CC_ALWAYS: taken = 1'b1;
         CC_ZERO:   taken = (tos_q == '0);
         CC_NZERO:  taken = (tos_q != '0);
         CC_NEG:    taken = tos_q[WIDTH-1];
         CC_CARRY:  taken = carry_q;
         default:   taken = 1'b0;
      endcase
   end

   // Next-state logic: faults are checked before any effect is applied.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tos_d   = tos_q;
      depth_d = depth_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_idx  = push_idx;
      if (state_q == ST_RUN && bus.i_instr_valid) begin
         if (depth_q < DEPTH_W'(need)) begin
            state_d = ST_FAULT;
            unf_d   = 1'b1;
         end else if (grows && depth_q == DEPTH_W'(DEPTH)) begin
            state_d = ST_FAULT;
            ovf_d   = 1'b1;
         end else begin
            pc_d = pc_q + IADDR_W'(1);
            case (cls)
               CLS_LIT: begin
                  wr_en   = (depth_q != '0);
                  tos_d   = payload;
                  depth_d = depth_q + DEPTH_W'(1);
               end
               CLS_OP: begin
                  case (op)
                     OP_ADD, OP_ADC: begin
                        tos_d   = sum_w[WIDTH-1:0];
                        carry_d = sum_w[WIDTH];
                        depth_d = depth_q - DEPTH_W'(1);
                     end
                     OP_SUB: begin
                        tos_d   = diff_w[WIDTH-1:0];
                        carry_d = diff_w[WIDTH];
                        depth_d = depth_q - DEPTH_W'(1);
                     end
                     OP_AND: begin
                        tos_d   = nos & tos_q;
                        depth_d = depth_q - DEPTH_W'(1);
                     end
                     OP_OR: begin
                        tos_d   = nos | tos_q;
                        depth_d = depth_q - DEPTH_W'(1);
                     end
                     OP_XOR: begin
                        tos_d   = nos ^ tos_q;
                        depth_d = depth_q - DEPTH_W'(1);
                     end
                     OP_NOT: tos_d = ~tos_q;
                     OP_DUP: begin
                        wr_en   = 1'b1;
                        depth_d = depth_q + DEPTH_W'(1);
                     end
                     OP_DROP: begin
                        tos_d   = nos;
                        depth_d = depth_q - DEPTH_W'(1);
                     end
                     OP_SWAP: begin
                        wr_en  = 1'b1;
                        wr_idx = s_idx;
                        tos_d  = nos;
                     end
                     OP_OVER: begin
                        wr_en   = 1'b1;
                        tos_d   = nos;
                        depth_d = depth_q + DEPTH_W'(1);
                     end
                     default: ;
                  endcase
               end
               CLS_JMP: if (taken) pc_d = payload[IADDR_W-1:0];
               default: begin
                  if (payload == WIDTH'(1)) begin
                     state_d = ST_HALT;
                     pc_d    = pc_q;
                  end
               end
            endcase
         end
      end
   end

   // Architectural registers; a synchronous reset overrides everything else.
   always_ff @(posedge i_clock) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (i_reset) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         tos_q   <= '0;
         depth_q <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tos_q   <= tos_d;
         depth_q <= depth_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage below the top entry; the top value is always the write data.
   always_ff @(posedge i_clock) begin
      // NOTE: the array is not reset; depth 0 makes stale contents unreachable.
      if (wr_en && !i_reset) mem_q[wr_idx] <= tos_q;
   end

   assign bus.o_iaddr     = pc_q;
   assign bus.o_tos       = (depth_q == '0) ? '0 : tos_q;
   assign bus.o_depth     = depth_q;
   assign bus.o_carry     = carry_q;
   assign bus.o_halted    = (state_q == ST_HALT);
   assign bus.o_fault     = (state_q == ST_FAULT);
   assign bus.o_overflow  = ovf_q;
   assign bus.o_underflow = unf_q;
endmodule

// File: doc/stack_core.md
STACK_CORE -- requirements
Module: stack_core

Interface
REQ-001 Parameter WIDTH, default 16: data word and stack entry width, at least 8.
REQ-002 Parameter DEPTH, default 16: stack capacity in entries, at least 2.
REQ-003 Parameter IADDR_W, default 12: instruction address width, at most WIDTH-3.
REQ-004 i_clock  in  1  sole clock, rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_instr  in  WIDTH+2  instruction at o_iaddr: [WIDTH+1:WIDTH] class, [WIDTH-1:0] payload.
REQ-007 i_instr_valid  in  1  i_instr valid this cycle; low means fetch stall.
REQ-008 o_iaddr  out  IADDR_W  program counter, driven straight from a register.
REQ-009 o_tos  out  WIDTH  top of stack; 0 when stack empty.
REQ-010 o_depth  out  clog2(DEPTH+1)  entries held, 0..DEPTH.
REQ-011 o_carry  out  1  carry flag.
REQ-012 o_halted  out  1  core in HALT state.
REQ-013 o_fault  out  1  core in FAULT state.
REQ-014 o_overflow / o_underflow  out  1 each  sticky cause of fault.

Function
REQ-015 States are RUN, HALT and FAULT; one instruction retires per clock in RUN when i_instr_valid=1.
REQ-016 In RUN with i_instr_valid=0: no state change; pc, stack and carry hold.
REQ-017 Class 01 (LIT): push payload, pc+1.
REQ-018 Class 00 (OP): payload[4:0] selects the operation; pc+1; all binary ops replace S with result, pop 1.
REQ-019 Binary ops:
- 0 ADD: S+T, carry=carry-out.
- 1 SUB: S-T, carry=1 iff S<T unsigned.
- 2 ADC: S+T+carry, carry=carry-out.
- 3 AND, 4 OR, 5 XOR: carry unchanged.
REQ-020 Stack ops:
- 6 NOT: T=~T, needs 1.
- 7 DUP: needs 1, push 1.
- 8 DROP: needs 1.
- 9 SWAP: needs 2.
- 10 OVER: push copy of S, needs 2.
- 11..31: NOP.
REQ-021 Class 10 (JMP): cond payload[WIDTH-1:WIDTH-3]:
- 000 always; 001 T==0; 010 T!=0; 011 T[WIDTH-1]=1; 100 carry=1; 101..111 never.
- Taken: pc=payload[IADDR_W-1:0]; not taken: pc+1.
- Stack never popped.
REQ-022 Conditions 001..011 on an empty stack are an underflow.
REQ-023 Class 11 (SYS): payload 0 is NOP; payload 1 enters HALT with pc frozen at the HALT address; other payloads are NOP.
REQ-024 Overflow: push (LIT, DUP, OVER) at depth==DEPTH leads to FAULT, sets o_overflow, and the instruction has no effect.
REQ-025 Underflow: depth below the operand need leads to FAULT, sets o_underflow, and the instruction has no effect.
REQ-026 HALT and FAULT are absorbing: pc, stack, carry and flags hold until reset, and i_instr is ignored.
REQ-027 pc increments modulo 2^IADDR_W; wrap from all-ones to 0 is legal, not a fault.
REQ-028 Arithmetic is modulo 2^WIDTH; carry is the bit WIDTH of the unsigned sum or borrow.
REQ-029 o_tos, o_depth and o_carry reflect state after the last retired instruction, with zero combinational path from i_instr.
REQ-030 Storage below the top entry is a DEPTH-entry register array or single-read/single-write RAM; the top entry is held in a register.

Reset
REQ-031 i_reset high at a clock edge sets: state RUN, pc 0, depth 0, carry 0, o_overflow 0, o_underflow 0.
REQ-032 Reset takes priority over every concurrent event, including a stall, HALT, FAULT, or an instruction in flight.
REQ-033 Array contents need not clear on reset; outputs SHALL not expose them while depth is 0 (o_tos=0).

Verification (WIDTH=16, DEPTH=4, IADDR_W=12)
REQ-034 LIT 0xFFFF, LIT 0x0002, ADD: o_tos=0x0001, o_carry=1, o_depth=1, o_iaddr=3.
REQ-035 LIT 5, JMP cond=010 target 0x020: o_iaddr=0x020 next cycle, o_depth stays 1.
REQ-036 Five LITs: the fifth sets o_fault=1 and o_overflow=1; o_depth=4; o_iaddr stays 4 on every later cycle.
REQ-037 ADD on an empty stack: o_underflow=1, o_fault=1, o_tos=0, carry unchanged.
REQ-038 Hold i_instr_valid=0 for 3 cycles mid-program: o_iaddr, o_tos and o_depth stay constant; execution resumes unchanged.
REQ-039 SYS HALT at address 7, then reset pulse: o_halted 1 until reset; after reset o_iaddr=0, o_depth=0, o_halted=0.
